// File: rtl/bcd_pkg.sv
// Shared constants and elaboration-time helpers for the BCD modulus counter.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX_DIGIT   = 4'h9;
  localparam int         MAX_DIGITS      = 4;
  localparam int         DEFAULT_MODULUS = 60;

  // 10 to the power n, used for decimal weighting of BCD digits.
  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

  // Packs a non-negative integer below 10000 into four BCD digits.
  function automatic logic [15:0] int_to_bcd(input int v);
    logic [15:0] r;
    int          t;
    r = 16'h0000;
    t = v;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t           = t / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the counter: holds a BCD digit, loads, or steps up/down.
// A stepping digit at its limit (9 going up, 0 going down) takes wrap_val.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       CP,
  input  logic       nCLR,
  input  logic       load,
  input  logic [3:0] d,
  input  logic       step,
  input  logic       dir,
  input  logic [3:0] wrap_val,
  output logic [3:0] q,
  output logic       at_limit
);

  logic [3:0] q_d;
  logic [3:0] q_q;
  logic       at_limit_s;

  // Digit is at its ripple limit for the current direction.
  always_comb begin
    if (dir) begin
      at_limit_s = (q_q == BCD_MAX_DIGIT);
    end else begin
      at_limit_s = (q_q == 4'h0);
    end
  end

  // Next digit value: load beats step; otherwise hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (step) begin
      if (at_limit_s) begin
        q_d = wrap_val;
      end else if (dir) begin
        q_d = q_q + 4'd1;
      end else begin
        q_d = q_q - 4'd1;
      end
    end else begin
      q_d = q_q;
    end
  end

  // Digit register, cleared asynchronously.
  always_ff @(posedge CP or negedge nCLR) begin
    if (!nCLR) begin
      q_q <= 4'h0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q        = q_q;
  assign at_limit = at_limit_s;

endmodule

// File: rtl/bcd_mod_counter.sv
// Up/down BCD counter with arbitrary modulus, validated parallel load,
// cascadable terminal count and a one-cycle rejected-load flag.
module bcd_mod_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic                  CP,
  input  logic                  nCLR,
  input  logic                  Load,
  input  logic                  En,
  input  logic                  dir,
  input  logic [4*DIGITS-1:0]   D,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  TC,
  output logic                  LoadErr
);

  localparam int          W         = 4 * DIGITS;
  localparam logic [15:0] MAX_BCD16 = int_to_bcd(MODULUS - 1);
  localparam logic [W-1:0] MAX_BCD  = MAX_BCD16[W-1:0];
  localparam logic [W-1:0] ZERO_BCD = {W{1'b0}};

  if (DIGITS < 1 || DIGITS > MAX_DIGITS || MODULUS < 2 || MODULUS > pow10(DIGITS)) begin : g_param_err
    $error("bcd_mod_counter: illegal DIGITS=%0d / MODULUS=%0d", DIGITS, MODULUS);
  end

  logic              d_ok_s;
  logic [13:0]       d_val_s;
  logic              load_ok_s;
  logic              at_max_s;
  logic              at_zero_s;
  logic              count_en_s;
  logic              mod_wrap_s;
  logic              dig_load_s;
  logic [W-1:0]      dig_d_s;
  logic [3:0]        wrap_val_s;
  logic [DIGITS-1:0] step_s;
  logic [DIGITS-1:0] at_limit_s;
  logic              load_err_d;
  logic              load_err_q;

  // Load validator: every digit must be decimal and the value below the modulus.
  always_comb begin
    d_ok_s  = 1'b1;
    d_val_s = 14'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (D[4*i +: 4] > BCD_MAX_DIGIT) begin
        d_ok_s = 1'b0;
      end else begin
        d_ok_s = d_ok_s;
      end
      d_val_s = d_val_s + 14'(D[4*i +: 4]) * 14'(pow10(i));
    end
    load_ok_s = d_ok_s && (d_val_s < 14'(MODULUS));
  end

  // Terminal count and modulus-wrap detection; a wrap is forced as a load.
  always_comb begin
    at_max_s   = (Q == MAX_BCD);
    at_zero_s  = (Q == ZERO_BCD);
    TC         = En && ((dir && at_max_s) || (!dir && at_zero_s));
    count_en_s = En && !Load;
    mod_wrap_s = count_en_s && ((dir && at_max_s) || (!dir && at_zero_s));
    dig_load_s = (Load && load_ok_s) || mod_wrap_s;
    if (Load) begin
      dig_d_s = D;
    end else if (dir) begin
      dig_d_s = ZERO_BCD;
    end else begin
      dig_d_s = MAX_BCD;
    end
    if (dir) begin
      wrap_val_s = 4'h0;
    end else begin
      wrap_val_s = BCD_MAX_DIGIT;
    end
    load_err_d = Load && !load_ok_s;
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign step_s[i] = count_en_s;
    end else begin : g_upper
      assign step_s[i] = count_en_s && (&at_limit_s[i-1:0]);
    end

    bcd_digit u_digit (
      .CP       (CP),
      .nCLR     (nCLR),
      .load     (dig_load_s),
      .d        (dig_d_s[4*i +: 4]),
      .step     (step_s[i]),
      .dir      (dir),
      .wrap_val (wrap_val_s),
      .q        (Q[4*i +: 4]),
      .at_limit (at_limit_s[i])
    );
  end

  // Rejected-load flag, valid for the single cycle after the request.
  always_ff @(posedge CP or negedge nCLR) begin
    if (!nCLR) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign LoadErr = load_err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Self-checking bench: three counter configurations share control inputs and
// are compared each cycle against an integer-valued reference model.
module tb_bcd_mod_counter;

  logic        CP;
  logic        nCLR;
  logic        Load;
  logic        En;
  logic        dir;
  logic [7:0]  da;
  logic [11:0] dc;
  logic [7:0]  qa;
  logic [7:0]  qb;
  logic [11:0] qc;
  logic        tca, tcb, tcc;
  logic        lea, leb, lec;

  int   tests = 0;
  int   fails = 0;
  int   va, vb, vc;
  logic ea, eb, ec;

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_a (
    .CP(CP), .nCLR(nCLR), .Load(Load), .En(En), .dir(dir),
    .D(da), .Q(qa), .TC(tca), .LoadErr(lea)
  );

  bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) u_b (
    .CP(CP), .nCLR(nCLR), .Load(Load), .En(En), .dir(dir),
    .D(da), .Q(qb), .TC(tcb), .LoadErr(leb)
  );

  bcd_mod_counter #(.DIGITS(3), .MODULUS(1000)) u_c (
    .CP(CP), .nCLR(nCLR), .Load(Load), .En(En), .dir(dir),
    .D(dc), .Q(qc), .TC(tcc), .LoadErr(lec)
  );

  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  // Decimal value of a BCD word; ok cleared if any digit is above 9.
  function automatic int dec_of(input logic [15:0] d, input int nd, output bit ok);
    int v;
    int w;
    v  = 0;
    w  = 1;
    ok = 1'b1;
    for (int i = 0; i < nd; i++) begin
      if (((d >> (4 * i)) & 16'hF) > 16'd9) ok = 1'b0;
      v = v + int'((d >> (4 * i)) & 16'hF) * w;
      w = w * 10;
    end
    return v;
  endfunction

  // Expected BCD rendering of an integer.
  function automatic logic [31:0] bcd_of(input int v);
    logic [31:0] r;
    int          t;
    r = 32'h0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r = r | (32'(t % 10) << (4 * i));
      t = t / 10;
    end
    return r;
  endfunction

  // Reference behaviour for one clock edge.
  task automatic model(inout int v, inout logic e, input logic [15:0] d, input int nd, input int m);
    bit ok;
    int dv;
    dv = dec_of(d, nd, ok);
    ok = ok && (dv < m);
    e  = Load && !ok;
    if (Load) begin
      if (ok) v = dv;
    end else if (En) begin
      v = dir ? (v + 1) % m : (v + m - 1) % m;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic tc_exp(input int v, input int m);
    return En && (dir ? (v == m - 1) : (v == 0));
  endfunction

  task automatic chk_state();
    chk("A.Q", 32'(qa), bcd_of(va));
    chk("B.Q", 32'(qb), bcd_of(vb));
    chk("C.Q", 32'(qc), bcd_of(vc));
    chk("A.LoadErr", 32'(lea), 32'(ea));
    chk("B.LoadErr", 32'(leb), 32'(eb));
    chk("C.LoadErr", 32'(lec), 32'(ec));
  endtask

  // One clock: check combinational TC, clock, update model, check registers.
  task automatic cyc();
    #1;
    chk("A.TC", 32'(tca), 32'(tc_exp(va, 60)));
    chk("B.TC", 32'(tcb), 32'(tc_exp(vb, 24)));
    chk("C.TC", 32'(tcc), 32'(tc_exp(vc, 1000)));
    @(posedge CP);
    model(va, ea, 16'(da), 2, 60);
    model(vb, eb, 16'(da), 2, 24);
    model(vc, ec, 16'(dc), 3, 1000);
    #1;
    chk_state();
  endtask

  task automatic do_load(input logic [7:0] a, input logic [11:0] c);
    Load = 1'b1;
    da   = a;
    dc   = c;
    cyc();
    Load = 1'b0;
  endtask

  task automatic async_clear();
    #2;
    nCLR = 1'b0;
    #1;
    va = 0; vb = 0; vc = 0;
    ea = 1'b0; eb = 1'b0; ec = 1'b0;
    chk_state();
    #2;
    nCLR = 1'b1;
  endtask

  initial begin
    nCLR = 1'b0;
    Load = 1'b0;
    En   = 1'b0;
    dir  = 1'b1;
    da   = 8'h00;
    dc   = 12'h000;
    va = 0; vb = 0; vc = 0;
    ea = 1'b0; eb = 1'b0; ec = 1'b0;
    #3;
    chk_state();
    #17;
    nCLR = 1'b1;

    // Full up-count lap of the modulus-60 counter: 00..59 then 00.
    En  = 1'b1;
    dir = 1'b1;
    repeat (60) cyc();

    // Down-count from 00 wraps to 59, then 58.
    dir = 1'b0;
    repeat (2) cyc();

    // Rejected loads hold Q and pulse LoadErr; a valid load is taken.
    do_load(8'h3A, 12'h03A);
    do_load(8'h75, 12'h075);
    do_load(8'h42, 12'h042);
    En = 1'b0;
    cyc();

    // Modulus 24: 23 wraps to 00 going up, 24 is rejected.
    do_load(8'h23, 12'h023);
    En  = 1'b1;
    dir = 1'b1;
    cyc();
    En = 1'b0;
    do_load(8'h24, 12'h024);

    // Three-digit ripple: 099 up to 100, back down to 099.
    do_load(8'h09, 12'h099);
    En  = 1'b1;
    dir = 1'b1;
    cyc();
    dir = 1'b0;
    cyc();

    // Asynchronous clear mid-count, after a rejected load, then load with En high.
    do_load(8'h37, 12'h037);
    do_load(8'hFF, 12'hFFF);
    En  = 1'b1;
    dir = 1'b1;
    async_clear();
    Load = 1'b1;
    da   = 8'h15;
    dc   = 12'h015;
    cyc();
    Load = 1'b0;

    // Randomised mix of loads, enables and direction changes.
    for (int n = 0; n < 400; n++) begin
      Load = ($urandom % 8) == 0;
      En   = ($urandom % 4) != 0;
      dir  = 1'($urandom % 2);
      if ($urandom % 2) begin
        da = {4'($urandom % 10), 4'($urandom % 10)};
        dc = {4'($urandom % 10), 4'($urandom % 10), 4'($urandom % 10)};
      end else begin
        da = 8'($urandom);
        dc = 12'($urandom);
      end
      cyc();
      if (n == 200) async_clear();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_mod_counter.md
BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

Interface
REQ-001 Parameter DIGITS, default 2: number of BCD digits, legal range 1..4.
REQ-002 Parameter MODULUS, default 60: count modulus, legal range 2..10^DIGITS; illegal values SHALL fail elaboration.
REQ-003 CP  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 nCLR  input  1  asynchronous, active-low reset.
REQ-005 Load  input  1  synchronous parallel load request.
REQ-006 En  input  1  count enable.
REQ-007 dir  input  1  1 = count up, 0 = count down.
REQ-008 D  input  4*DIGITS  BCD load value; digit i is D[4i+3:4i].
REQ-009 Q  output  4*DIGITS  registered BCD count; digit i is Q[4i+3:4i].
REQ-010 TC  output  1  combinational terminal count, used to cascade into the next stage's En.
REQ-011 LoadErr  output  1  registered one-cycle flag indicating a rejected load.

Function
REQ-012 Priority SHALL be nCLR, then Load, then En; Load SHALL act regardless of En.
REQ-013 A load SHALL be valid only if every digit of D is ≤9 and the decimal value of D is < MODULUS.
REQ-014 On a valid Load, Q SHALL equal D on the next edge and LoadErr SHALL be 0.
REQ-015 On an invalid Load, Q SHALL hold, counting SHALL be suppressed that cycle, and LoadErr SHALL be 1 for exactly the following cycle.
REQ-016 With Load=0, En=1, dir=1: Q increments by 1 in decimal; from MODULUS-1 it SHALL wrap to 0.
REQ-017 With Load=0, En=1, dir=0: Q decrements by 1 in decimal; from 0 it SHALL wrap to MODULUS-1.
REQ-018 Decimal arithmetic SHALL be ripple-per-digit: digit i steps only when all lower digits are at 9 (up) or 0 (down); a stepping digit wraps 9→0 (up) or 0→9 (down), except at the modulus wrap in REQ-016/017.
REQ-019 With En=0 and Load=0, Q SHALL hold.
REQ-020 TC SHALL be En && ((dir && Q==MODULUS-1) || (!dir && Q==0)), with no dependence on Load.
REQ-021 A dir change SHALL take effect on the same edge; there is no direction pipeline.
REQ-022 Latency: every Q update SHALL be visible one CP edge after the qualifying inputs.
REQ-023 Q SHALL never hold a non-BCD digit or a value ≥ MODULUS in operation.

Reset
REQ-024 While nCLR=0, Q SHALL be 0 and LoadErr SHALL be 0, immediately and independently of CP.
REQ-025 Deassertion of nCLR SHALL be synchronised externally; the first active edge after release SHALL obey REQ-012.
REQ-026 A reset asserted mid-count or mid-load SHALL discard that operation; no pending state survives.

Structure
REQ-027 Shared package bcd_pkg SHALL hold BCD_MAX_DIGIT (4'h9), MAX_DIGITS (4), and DEFAULT_MODULUS (60).
REQ-028 Each digit SHALL be one instance of sub-module bcd_digit, generated DIGITS times.
REQ-029 bcd_digit SHALL have inputs CP, nCLR, load, d[3:0], step, dir, and wrap_val[3:0], and outputs q[3:0] and at_limit.
REQ-030 The top level SHALL contain the load validator, the modulus-wrap detection, the TC logic, and the LoadErr register.

Verification
REQ-031 Default parameters, nCLR pulse, then En=1, dir=1 for 61 cycles → Q runs 00…59, 00; TC=1 only while Q=59.
REQ-032 Default parameters, Q=00, En=1, dir=0 → Q=59 next, then 58; TC=1 during Q=00.
REQ-033 Load=1, D=8'h3A, then D=8'h75 → Q holds both times and LoadErr pulses each time; then D=8'h42 → Q=42 and LoadErr=0.
REQ-034 DIGITS=2, MODULUS=24, up count from 23 → 00; Load of D=8'h24 is rejected.
REQ-035 DIGITS=3, MODULUS=1000, Q=099, up → 100; Q=100, down → 099.
REQ-036 Q=37 with En=1; nCLR asserted between edges → Q=00 at once and LoadErr=0; Load=1 and En=1 together with D=8'h15 → Q=15.
